// File: rtl/cache_pkg.sv
// rtl/cache_pkg.sv - shared cache-line geometry and serializer state encoding
package cache_pkg;

    localparam int WORD_W = 32;
    localparam int WORDS  = 8;
    localparam int LINE_W = WORD_W * WORDS;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } ser_state_t;

endpackage

// File: rtl/serializer.sv
// rtl/serializer.sv - cache line to memory-word serializer (optional SERIALIZER_LINE_CNT_EN line counter)
module serializer #(
    parameter int WORD_W = cache_pkg::WORD_W,
    parameter int WORDS  = cache_pkg::WORDS
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [WORD_W*WORDS-1:0] line_in,
    input  logic                    line_valid,
    output logic                    line_ready,
    output logic [WORD_W-1:0]       word_out,
    output logic                    word_valid,
    input  logic                    word_ready,
    output logic                    word_last,
    output logic                    busy
`ifdef SERIALIZER_LINE_CNT_EN
    ,
    output logic [31:0]             lines_sent
`endif
);

    import cache_pkg::*;

    localparam int LINE_W = WORD_W * WORDS;
    localparam int CNT_W  = $clog2(WORDS);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WORDS - 1);

    ser_state_t        state_q;
    ser_state_t        state_d;
    logic [LINE_W-1:0] shreg_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              accept;
    logic              word_hs;
    logic              at_last;

    assign at_last = (cnt_q == LAST);
    assign accept  = line_valid && line_ready;
    assign word_hs = word_valid && word_ready;

    // State register; reset abandons any line in flight
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and handshake outputs; line_ready is held low while reset is asserted
    always_comb begin
        state_d    = state_q;
        line_ready = 1'b0;
        word_valid = 1'b0;
        busy       = 1'b0;
        word_last  = 1'b0;
        case (state_q)
            IDLE: begin
                line_ready = rst_n;
                if (line_valid && rst_n) begin
                    state_d = SEND;
                end
            end
            SEND: begin
                word_valid = 1'b1;
                busy       = 1'b1;
                word_last  = at_last;
                if (word_ready && at_last) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Shift register and word index; word 0 sits in the low bits, so shifting right walks the line
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            shreg_q <= '0;
            cnt_q   <= '0;
        end else if (accept) begin
            shreg_q <= line_in;
            cnt_q   <= '0;
        end else if (word_hs) begin
            shreg_q <= shreg_q >> WORD_W;
            cnt_q   <= at_last ? '0 : cnt_q + 1'b1;
        end
    end

    assign word_out = shreg_q[WORD_W-1:0];

`ifdef SERIALIZER_LINE_CNT_EN
    logic [31:0] line_cnt_q;

    // Completed-line counter, free-running with natural wrap
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            line_cnt_q <= '0;
        end else if (word_hs && word_last) begin
            line_cnt_q <= line_cnt_q + 32'd1;
        end
    end

    assign lines_sent = line_cnt_q;
`endif

endmodule

// File: tb/tb_serializer.sv
// tb/tb_serializer.sv - scoreboard bench for serializer (SERIALIZER_LINE_CNT_EN optional)
module tb_serializer;

    logic         clk;
    logic         rst_n;
    logic [255:0] line_in;
    logic         line_valid;
    logic         line_ready;
    logic [31:0]  word_out;
    logic         word_valid;
    logic         word_ready;
    logic         word_last;
    logic         busy;
`ifdef SERIALIZER_LINE_CNT_EN
    logic [31:0]  lines_sent;
`endif

    serializer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .line_in    (line_in),
        .line_valid (line_valid),
        .line_ready (line_ready),
        .word_out   (word_out),
        .word_valid (word_valid),
        .word_ready (word_ready),
        .word_last  (word_last),
        .busy       (busy)
`ifdef SERIALIZER_LINE_CNT_EN
        ,
        .lines_sent (lines_sent)
`endif
    );

    typedef struct {
        logic [31:0] w;
        logic        l;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          pops = 0;
    int          last_pop_cyc = 0;
    int          lines_done = 0;
    int          mode = 0;
    int          rk = 0;
    bit          stall_prev = 0;
    logic [31:0] held_w = '0;
    logic        held_l = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // word_ready pattern: 0 always high, 1 random, 2 repeating 1,0,0
    initial begin
        word_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            rk++;
            case (mode)
                0:       word_ready = 1'b1;
                1:       word_ready = 1'($urandom_range(0, 1));
                default: word_ready = (rk % 3 == 0);
            endcase
        end
    end

    // Monitor: pops expected words on each handshake and checks holds across stalls
    always @(negedge clk) begin
        if (rst_n) begin
            if (stall_prev) begin
                chk("hold_word", word_out, held_w);
                chk("hold_last", word_last, held_l);
            end
            chk("busy_eq_valid", busy, word_valid);
            if (word_valid) chk("line_ready_in_send", line_ready, 1'b0);
            if (word_valid && word_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_word actual=%0h required=none at cycle %0d", word_out, cyc);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("word", word_out, e.w);
                    chk("word_last", word_last, e.l);
                    if (e.l) lines_done++;
                    pops++;
                    last_pop_cyc = cyc;
                end
            end
            stall_prev = word_valid && !word_ready;
            held_w     = word_out;
            held_l     = word_last;
        end else begin
            stall_prev = 0;
        end
    end

    // Offer a line; expected words are the line's 32-bit slices in ascending order
    task automatic send_line(input logic [255:0] l, input bit hold, output int acc);
        int  n;
        bit  ok;
        n  = 0;
        ok = 0;
        line_in    = l;
        line_valid = 1'b1;
        while (!ok && n < 300) begin
            @(negedge clk);
            if (line_ready) ok = 1;
            n++;
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout actual=no_accept required=accept at cycle %0d", cyc);
            line_valid = 1'b0;
            acc = -1;
        end else begin
            for (int i = 0; i < 8; i++) begin
                exp_t e;
                e.w = l[32*i +: 32];
                e.l = (i == 7);
                sb.push_back(e);
            end
            @(posedge clk);
            #1;
            acc = cyc;
            if (!hold) line_valid = 1'b0;
        end
    endtask

    task automatic drain(input int lim);
        int n;
        n = 0;
        while (sb.size() != 0 && n < lim) begin
            @(negedge clk);
            #2;
            n++;
        end
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout actual=%0d required=0 words pending", sb.size());
        end
    endtask

    function automatic logic [255:0] rand_line();
        logic [255:0] l;
        for (int i = 0; i < 8; i++) l[32*i +: 32] = $urandom;
        return l;
    endfunction

    initial begin
        #3_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [255:0] l;
        logic [255:0] la;
        logic [255:0] lb;
        int acc;
        int acc_a;
        int acc_b;
        int base;
        int n;

        rst_n      = 1'b0;
        line_valid = 1'b0;
        line_in    = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_word_valid", word_valid, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_word_last", word_last, 1'b0);
        chk("rst_word_out", word_out, 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_line_ready", line_ready, 1'b1);

        // Word i = i, ready held high: exact latency and return to IDLE
        @(posedge clk);
        #1;
        for (int i = 0; i < 8; i++) l[32*i +: 32] = 32'(i);
        send_line(l, 0, acc);
        drain(50);
        chk("last_word_cycle", 64'(last_pop_cyc), 64'(acc + 7));
        @(negedge clk);
        chk("line_ready_after", line_ready, 1'b1);
        chk("idle_word_out", word_out, 32'h0);

        // Ready pattern 1,0,0 with stalls
        mode = 2;
        @(posedge clk);
        #1;
        send_line(rand_line(), 0, acc);
        drain(100);
        mode = 0;

        // Back-to-back lines with junk on line_in during SEND
        @(posedge clk);
        #1;
        la = rand_line();
        lb = rand_line();
        send_line(la, 1, acc_a);
        for (int j = 0; j < 3; j++) begin
            @(posedge clk);
            #1;
            line_in = rand_line();
        end
        send_line(lb, 0, acc_b);
        drain(50);
        chk("b2b_spacing", 64'(acc_b - acc_a), 64'd9);

        // Reset after word 3 handshake
        @(posedge clk);
        #1;
        base = pops;
        send_line(rand_line(), 0, acc);
        n = 0;
        while (pops < base + 4 && n < 50) begin
            @(negedge clk);
            #2;
            n++;
        end
        chk("pre_reset_pops", 64'(pops - base), 64'd4);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        sb.delete();
        @(negedge clk);
        chk("mid_rst_word_valid", word_valid, 1'b0);
        chk("mid_rst_busy", busy, 1'b0);
        chk("mid_rst_word_last", word_last, 1'b0);
        chk("mid_rst_word_out", word_out, 32'h0);
        @(posedge clk);
        #1;
        rst_n      = 1'b1;
        lines_done = 0;
        @(negedge clk);
        chk("mid_rst_line_ready", line_ready, 1'b1);
        @(posedge clk);
        #1;
        send_line(rand_line(), 0, acc);
        drain(50);

        // Random lines, random gaps, random ready
        mode = 1;
        for (int k = 0; k < 25; k++) begin
            @(posedge clk);
            #1;
            send_line(rand_line(), 1'($urandom_range(0, 1)), acc);
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
        end
        line_valid = 1'b0;
        drain(2000);
        mode = 0;

`ifdef SERIALIZER_LINE_CNT_EN
        @(negedge clk);
        chk("lines_sent", lines_sent, 32'(lines_done));
        force dut.line_cnt_q = 32'hFFFF_FFFF;
        @(posedge clk);
        #1;
        release dut.line_cnt_q;
        send_line(rand_line(), 0, acc);
        drain(50);
        @(negedge clk);
        chk("lines_sent_wrap", lines_sent, 32'h0);
`endif

        repeat (3) @(negedge clk);
        chk("sb_empty", 64'(sb.size()), 64'd0);
        chk("no_valid_at_end", word_valid, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
